// File: rtl/kbd_fifo_mmio.sv
// Keyboard receive FIFO with memory-mapped KBSR/KBDR for the eLC-3 I/O page.
// Optional interrupt request and IE bit are built only when KBD_FIFO_IRQ_EN is defined.
module kbd_fifo_mmio #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter logic [15:0] KBSR_ADDR = 16'hFE00,
  parameter logic [15:0] KBDR_ADDR = 16'hFE02
) (
  input  logic              Clk,
  input  logic              Reset_N,
  input  logic              KeyValid,
  input  logic [DATA_W-1:0] KeyData,
  input  logic [15:0]       Address,
  input  logic              MIO_EN,
  input  logic              R_W,
  input  logic [15:0]       Data_In,
  output logic [15:0]       Data_Out,
  output logic              Hit,
  output logic              Irq
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              acc_q;
  logic [15:0]       data_out_q, data_out_d;
  logic              ie_c;

  logic acc_kbdr_c, rd_kbsr_c, wr_kbsr_c;
  logic empty_c, full_c, pop_first_c, pop_c, push_c, ovf_set_c;
  logic [15:0] kbsr_c;
  logic unused_c;

  assign acc_kbdr_c = MIO_EN & ~R_W & (Address == KBDR_ADDR);
  assign rd_kbsr_c  = MIO_EN & ~R_W & (Address == KBSR_ADDR);
  assign wr_kbsr_c  = MIO_EN &  R_W & (Address == KBSR_ADDR);
  assign Hit        = MIO_EN & ((Address == KBSR_ADDR) | (Address == KBDR_ADDR));
  assign empty_c    = (count_q == CNT_W'(0));
  assign full_c     = (count_q == CNT_W'(DEPTH));
  assign kbsr_c     = {~empty_c, ie_c, ovf_q, 5'b0, 8'(count_q)};
  assign unused_c   = ^Data_In;
  assign Data_Out   = data_out_q;

  // Next-state: a held KBDR read pops only on its first cycle; a pop frees room for a same-cycle push
  always_comb begin
    pop_first_c = acc_kbdr_c & ~acc_q;
    pop_c       = pop_first_c & ~empty_c;
    push_c      = KeyValid & (~full_c | pop_c);
    ovf_set_c   = KeyValid & full_c & ~pop_c;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    data_out_d  = 16'h0000;

    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (wr_kbsr_c && Data_In[13]) ovf_d = 1'b0;
    if (ovf_set_c)                ovf_d = 1'b1;

    if (rd_kbsr_c) begin
      data_out_d = kbsr_c;
    end else if (acc_kbdr_c) begin
      if (pop_first_c) data_out_d = pop_c ? 16'(mem_q[rd_ptr_q]) : 16'h0000;
      else             data_out_d = data_out_q;
    end
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      acc_q      <= 1'b0;
      data_out_q <= 16'h0000;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      acc_q      <= acc_kbdr_c;
      data_out_q <= data_out_d;
    end
  end

  // Storage array carries no reset; entries are only read once written
  always_ff @(posedge Clk) begin
    if (push_c) mem_q[wr_ptr_q] <= KeyData;
  end

`ifdef KBD_FIFO_IRQ_EN
  logic ie_q, ie_d;
  logic irq_q, irq_d;

  always_comb begin
    ie_d  = wr_kbsr_c ? Data_In[14] : ie_q;
    irq_d = ie_d & (count_d != CNT_W'(0));
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ie_q  <= ie_d;
      irq_q <= irq_d;
    end
  end

  assign ie_c = ie_q;
  assign Irq  = irq_q;
`else
  assign ie_c = 1'b0;
  assign Irq  = 1'b0;
`endif

endmodule

// File: tb/tb_kbd_fifo_mmio.sv
// Self-checking bench for kbd_fifo_mmio: queue-based reference model compared every cycle,
// plus directed reads with literal expectations. Honours KBD_FIFO_IRQ_EN when defined.
module tb_kbd_fifo_mmio;

  localparam int unsigned DEPTH = 16;
  localparam logic [15:0] KBSR  = 16'hFE00;
  localparam logic [15:0] KBDR  = 16'hFE02;

  logic        Clk = 1'b0;
  logic        Reset_N = 1'b1;
  logic        KeyValid = 1'b0;
  logic [7:0]  KeyData = 8'h00;
  logic [15:0] Address = 16'h0000;
  logic        MIO_EN = 1'b0;
  logic        R_W = 1'b0;
  logic [15:0] Data_In = 16'h0000;
  logic [15:0] Data_Out;
  logic        Hit;
  logic        Irq;

  int errors = 0;
  int checks = 0;

  kbd_fifo_mmio #(.DATA_W(8), .DEPTH(DEPTH), .KBSR_ADDR(KBSR), .KBDR_ADDR(KBDR)) dut (
    .Clk(Clk), .Reset_N(Reset_N), .KeyValid(KeyValid), .KeyData(KeyData),
    .Address(Address), .MIO_EN(MIO_EN), .R_W(R_W), .Data_In(Data_In),
    .Data_Out(Data_Out), .Hit(Hit), .Irq(Irq)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of keystrokes and the register rules applied at each clock
  logic [7:0]  mq[$];
  logic        m_ovf = 1'b0, m_ie = 1'b0, m_prev = 1'b0;
  logic [15:0] exp_do = 16'h0000;
  logic        exp_irq = 1'b0;
  logic [15:0] m_sr;
  logic        m_acc, m_rs, m_ws, m_first;

  always @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      mq.delete();
      m_ovf = 1'b0; m_ie = 1'b0; m_prev = 1'b0;
      exp_do = 16'h0000; exp_irq = 1'b0;
    end else begin
      m_sr    = {(mq.size() != 0), m_ie, m_ovf, 5'b0, 8'(mq.size())};
      m_acc   = MIO_EN && !R_W && (Address == KBDR);
      m_rs    = MIO_EN && !R_W && (Address == KBSR);
      m_ws    = MIO_EN &&  R_W && (Address == KBSR);
      m_first = m_acc && !m_prev;
      if (m_rs) exp_do = m_sr;
      else if (m_acc) begin
        if (m_first) exp_do = (mq.size() != 0) ? {8'h00, mq[0]} : 16'h0000;
      end else exp_do = 16'h0000;
      if (m_first && mq.size() != 0) void'(mq.pop_front());
      if (m_ws) begin
`ifdef KBD_FIFO_IRQ_EN
        m_ie = Data_In[14];
`endif
        if (Data_In[13]) m_ovf = 1'b0;
      end
      if (KeyValid) begin
        if (mq.size() < DEPTH) mq.push_back(KeyData);
        else m_ovf = 1'b1;
      end
      exp_irq = m_ie && (mq.size() != 0);
      m_prev  = m_acc;
    end
  end

  always @(posedge Clk) begin
    #1;
    if (Reset_N) begin
      check("cyc_data_out", Data_Out, exp_do);
      check("cyc_irq", {15'b0, Irq}, {15'b0, exp_irq});
      check("cyc_hit", {15'b0, Hit},
            {15'b0, (MIO_EN && (Address == KBSR || Address == KBDR))});
    end
  end

  task automatic drive(input logic kv, input logic [7:0] kd, input logic mio,
                       input logic rw, input logic [15:0] a, input logic [15:0] din);
    @(negedge Clk);
    KeyValid = kv; KeyData = kd; MIO_EN = mio; R_W = rw; Address = a; Data_In = din;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic push(input logic [7:0] v);
    drive(1'b1, v, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic rd(input string name, input logic [15:0] a, input logic [15:0] exp);
    drive(1'b0, 8'h00, 1'b1, 1'b0, a, 16'h0000);
    @(posedge Clk); #2;
    check(name, Data_Out, exp);
    idle();
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    drive(1'b0, 8'h00, 1'b1, 1'b1, a, d);
    idle();
  endtask

  initial begin
    #1 Reset_N = 1'b0;
    repeat (3) @(posedge Clk);
    #2;
    check("reset_data_out", Data_Out, 16'h0000);
    check("reset_irq", {15'b0, Irq}, 16'h0000);
    @(negedge Clk) Reset_N = 1'b1;

    // Single keystroke
    push(8'h41);
    rd("A_kbsr_ready", KBSR, 16'h8001);
    rd("A_kbdr", KBDR, 16'h0041);
    rd("A_kbsr_empty", KBSR, 16'h0000);

    // Overflow: 18 keys into 16 entries
    for (int i = 1; i <= 18; i++) push(8'(i));
    rd("ovf_kbsr", KBSR, 16'hA010);
    for (int i = 1; i <= 16; i++) rd("ovf_drain", KBDR, 16'(i));
    wr(KBSR, 16'h2000);
    rd("ovf_cleared", KBSR, 16'h0000);

    // Held KBDR read pops once
    push(8'h11); push(8'h22); push(8'h33);
    drive(1'b0, 8'h00, 1'b1, 1'b0, KBDR, 16'h0000);
    for (int c = 0; c < 5; c++) begin
      @(posedge Clk); #2;
      check("hold_data", Data_Out, 16'h0011);
    end
    idle();
    rd("hold_count", KBSR, 16'h8002);
    rd("hold_next1", KBDR, 16'h0022);
    rd("hold_next2", KBDR, 16'h0033);

    // Full FIFO: push and pop in the same cycle, then wrap pointers
    for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
    rd("full_kbsr", KBSR, 16'h8010);
    drive(1'b1, 8'hC0, 1'b1, 1'b0, KBDR, 16'h0000);
    @(posedge Clk); #2;
    check("full_pushpop_data", Data_Out, 16'h0040);
    idle();
    rd("full_pushpop_kbsr", KBSR, 16'h8010);
    for (int k = 0; k < 32; k++) begin
      drive(1'b1, 8'(8'h80 + k), 1'b1, 1'b0, KBDR, 16'h0000);
      @(posedge Clk); #2;
      if (k < 15)       check("wrap_pair", Data_Out, 16'(16'h41 + k));
      else if (k == 15) check("wrap_pair", Data_Out, 16'h00C0);
      else              check("wrap_pair", Data_Out, 16'(16'h80 + k - 16));
      idle();
    end
    rd("wrap_kbsr", KBSR, 16'h8010);
    for (int i = 0; i < 16; i++) rd("wrap_drain", KBDR, 16'(16'h90 + i));
    rd("wrap_empty", KBSR, 16'h0000);

    // Empty pop, then reset during a held access
    rd("empty_pop", KBDR, 16'h0000);
    rd("empty_kbsr", KBSR, 16'h0000);
    push(8'h05); push(8'h06); push(8'h07); push(8'h08);
    drive(1'b0, 8'h00, 1'b1, 1'b0, KBDR, 16'h0000);
    @(posedge Clk); #2;
    check("pre_reset_pop", Data_Out, 16'h0005);
    #1 Reset_N = 1'b0;
    #1;
    check("midreset_data", Data_Out, 16'h0000);
    check("midreset_irq", {15'b0, Irq}, 16'h0000);
    @(negedge Clk) Reset_N = 1'b1;
    @(posedge Clk); #2;
    check("release_pop", Data_Out, 16'h0000);
    idle();
    rd("release_kbsr", KBSR, 16'h0000);

    // Interrupt enable
    wr(KBSR, 16'h4000);
    push(8'h5A);
    @(posedge Clk); #2;
`ifdef KBD_FIFO_IRQ_EN
    check("irq_rise", {15'b0, Irq}, 16'h0001);
    rd("irq_kbsr", KBSR, 16'hC001);
    check("irq_held", {15'b0, Irq}, 16'h0001);
    drive(1'b0, 8'h00, 1'b1, 1'b0, KBDR, 16'h0000);
    @(posedge Clk); #2;
    check("irq_pop_data", Data_Out, 16'h005A);
    check("irq_fall", {15'b0, Irq}, 16'h0000);
    idle();
    rd("irq_kbsr_after", KBSR, 16'h4000);
    wr(KBSR, 16'h0000);
`else
    check("irq_off", {15'b0, Irq}, 16'h0000);
    rd("ie_off_kbsr", KBSR, 16'h8001);
    check("irq_off_held", {15'b0, Irq}, 16'h0000);
    rd("ie_off_pop", KBDR, 16'h005A);
`endif

    // KBDR write has no effect
    wr(KBDR, 16'h1234);
    rd("kbdr_write_ignored", KBSR, 16'h0000);

    repeat (2) @(posedge Clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
